// File: rtl/router_rd_client.sv
// Read client for one router output port: pulls header/payload/parity beats from the port FIFO,
// streams them to a sink, checks XOR parity and keeps good/error packet counts.
module router_rd_client #(
  parameter int START_DLY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  input  logic        soft_reset,
  input  logic        sink_ready,
  output logic        read_enb,
  output logic [7:0]  pkt_data,
  output logic        pkt_valid,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic [5:0]  pkt_len,
  output logic        parity_err,
  output logic        drop,
  output logic [15:0] good_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE, DELAY, RD_HDR, HDR_WAIT, RD_PLD, RD_PAR, PAR_WAIT
  } state_t;

  // The IDLE cycle that sees vld_out counts as the first delay cycle, so the
  // first read lands START_DLY cycles after vld_out rises (never sooner than 1).
  localparam bit       SKIP_DLY = (START_DLY <= 1);
  localparam logic [4:0] DLY_LOAD = SKIP_DLY ? 5'd0 : 5'(START_DLY - 2);

  state_t      state;
  logic [4:0]  dly_cnt;
  logic [5:0]  pld_cnt;
  logic [7:0]  xor_acc;
  logic [7:0]  last_data;
  logic        eop_q;
  logic        abort;
  logic        rd_state;
  logic        par_bad;

  assign abort    = soft_reset && (state != IDLE);
  assign rd_state = (state == RD_HDR) || (state == RD_PLD) || (state == RD_PAR);
  assign read_enb = rst && rd_state && vld_out && sink_ready && !soft_reset;
  assign par_bad  = (data_out != xor_acc);

  // FIFO data arrives the cycle after the strobe, so the beat is passed straight through.
  assign pkt_data   = pkt_valid ? data_out : last_data;
  assign pkt_eop    = eop_q && !abort;
  assign parity_err = (state == PAR_WAIT) && !soft_reset && par_bad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      dly_cnt   <= 5'd0;
      pld_cnt   <= 6'd0;
      xor_acc   <= 8'h00;
      last_data <= 8'h00;
      pkt_valid <= 1'b0;
      pkt_sop   <= 1'b0;
      eop_q     <= 1'b0;
      pkt_len   <= 6'd0;
      drop      <= 1'b0;
      good_cnt  <= 16'd0;
      err_cnt   <= 8'd0;
    end else begin
      pkt_valid <= read_enb;
      pkt_sop   <= read_enb && (state == RD_HDR);
      eop_q     <= read_enb && (state == RD_PAR);
      drop      <= 1'b0;
      if (pkt_valid) last_data <= data_out;

      if (abort) begin
        state   <= IDLE;
        drop    <= 1'b1;
        xor_acc <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            if (vld_out) begin
              if (SKIP_DLY) begin
                state   <= RD_HDR;
                xor_acc <= 8'h00;
              end else begin
                state   <= DELAY;
                dly_cnt <= DLY_LOAD;
              end
            end
          end
          DELAY: begin
            if (dly_cnt == 5'd0) begin
              state   <= RD_HDR;
              xor_acc <= 8'h00;
            end else begin
              dly_cnt <= dly_cnt - 5'd1;
            end
          end
          RD_HDR: begin
            if (read_enb) state <= HDR_WAIT;
          end
          HDR_WAIT: begin
            pkt_len <= data_out[7:2];
            pld_cnt <= data_out[7:2];
            xor_acc <= xor_acc ^ data_out;
            state   <= (data_out[7:2] != 6'd0) ? RD_PLD : RD_PAR;
          end
          RD_PLD: begin
            if (pkt_valid) xor_acc <= xor_acc ^ data_out;
            if (read_enb) begin
              pld_cnt <= pld_cnt - 6'd1;
              if (pld_cnt == 6'd1) state <= RD_PAR;
            end
          end
          RD_PAR: begin
            // last payload beat may still be landing here
            if (pkt_valid) xor_acc <= xor_acc ^ data_out;
            if (read_enb) state <= PAR_WAIT;
          end
          PAR_WAIT: begin
            if (par_bad) begin
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
              good_cnt <= good_cnt + 16'd1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_rd_client.sv
// Bench for router_rd_client: a queue-based FIFO/packet model predicts every beat, marker,
// pulse and counter; directed scenarios plus randomized packets and sink/vld behaviour.
module tb_router_rd_client;
  localparam int DLY = 4;
  localparam int LAT = (DLY < 1) ? 1 : DLY;

  logic        clk = 1'b0;
  logic        rst, vld_out, soft_reset, sink_ready;
  logic [7:0]  data_out;
  logic        read_enb, pkt_valid, pkt_sop, pkt_eop, parity_err, drop;
  logic [7:0]  pkt_data, err_cnt;
  logic [5:0]  pkt_len;
  logic [15:0] good_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_b[$];
  int          fifo_t[$];
  bit          exp_ok[$];
  int          hdr_cyc[$];

  logic        exp_v = 1'b0;
  logic [7:0]  exp_d = 8'h00;
  int          exp_t = 0;
  logic        drop_pend = 1'b0;
  logic [5:0]  exp_len = 6'd0;
  logic [15:0] exp_good = 16'd0;
  logic [7:0]  exp_err = 8'd0;
  logic        exp_abort = 1'b0;
  logic        vld_gate = 1'b1;
  logic        last_rd = 1'b0;
  int          last_t = 0;
  int          mode = 0;
  int          cyc_n = 0;

  router_rd_client #(.START_DLY(DLY)) dut (
    .clk(clk), .rst(rst), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .sink_ready(sink_ready), .read_enb(read_enb),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_len(pkt_len), .parity_err(parity_err), .drop(drop),
    .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] par_of(input logic [7:0] hdr, input logic [63:0] pld);
    logic [7:0] x;
    x = hdr;
    for (int i = 0; i < 8; i++)
      if (i < int'(hdr[7:2])) x = x ^ pld[8*i +: 8];
    return x;
  endfunction

  task automatic push_pkt(input logic [7:0] hdr, input logic [63:0] pld, input logic [7:0] par);
    fifo_b.push_back(hdr);
    fifo_t.push_back(0);
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      fifo_b.push_back(pld[8*i +: 8]);
      fifo_t.push_back(1);
    end
    fifo_b.push_back(par);
    fifo_t.push_back(2);
    exp_ok.push_back(par == par_of(hdr, pld));
    vld_out = vld_gate && (fifo_b.size() > 0);
  endtask

  task automatic reset_checks();
    chk("rst_read_enb", 32'(read_enb), 32'd0);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_pkt_sop", 32'(pkt_sop), 32'd0);
    chk("rst_pkt_eop", 32'(pkt_eop), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_pkt_data", 32'(pkt_data), 32'd0);
    chk("rst_pkt_len", 32'(pkt_len), 32'd0);
    chk("rst_good_cnt", 32'(good_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
  endtask

  // One clock cycle: entered at posedge+1 with inputs applied, returns at the next posedge+1.
  task automatic cyc();
    logic       rd;
    logic       ok;
    logic       len_upd;
    logic [5:0] len_pend;
    logic [7:0] pop_b;
    int         pop_t;
    pop_b = 8'h00;
    pop_t = 0;
    len_pend = 6'd0;
    #1;
    chk("pkt_valid", 32'(pkt_valid), 32'(exp_v));
    if (exp_v) begin
      chk("pkt_data", 32'(pkt_data), 32'(exp_d));
      chk("pkt_sop", 32'(pkt_sop), 32'(exp_t == 0));
      chk("pkt_eop", 32'(pkt_eop), 32'(exp_t == 2 && !exp_abort));
    end
    ok = 1'b1;
    if (exp_v && exp_t == 2 && !exp_abort && exp_ok.size() > 0) ok = exp_ok[0];
    chk("parity_err", 32'(parity_err), 32'(exp_v && exp_t == 2 && !exp_abort && !ok));
    chk("drop", 32'(drop), 32'(drop_pend));
    chk("good_cnt", 32'(good_cnt), 32'(exp_good));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("pkt_len", 32'(pkt_len), 32'(exp_len));
    if (!sink_ready || soft_reset || !vld_out || !rst)
      chk("read_gated", 32'(read_enb), 32'd0);
    rd = read_enb;
    last_rd = rd;

    if (exp_v && exp_t == 2 && !exp_abort) begin
      if (exp_ok.size() > 0) void'(exp_ok.pop_front());
      if (ok) exp_good = exp_good + 16'd1;
      else if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    end
    len_upd = exp_v && exp_t == 0 && !exp_abort;
    if (len_upd) len_pend = exp_d[7:2];
    drop_pend = exp_abort;
    if (rd && fifo_b.size() > 0) begin
      pop_b = fifo_b.pop_front();
      pop_t = fifo_t.pop_front();
      last_t = pop_t;
      if (pop_t == 0) hdr_cyc.push_back(cyc_n);
    end
    if (exp_abort) begin
      while (fifo_t.size() > 0 && fifo_t[0] != 0) begin
        void'(fifo_b.pop_front());
        void'(fifo_t.pop_front());
      end
      if (exp_ok.size() > 0) void'(exp_ok.pop_front());
    end
    if (!rst) begin
      fifo_b.delete();
      fifo_t.delete();
      exp_ok.delete();
      exp_good = 16'd0;
      exp_err = 8'd0;
      exp_len = 6'd0;
      len_upd = 1'b0;
      drop_pend = 1'b0;
      rd = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc_n++;
    if (len_upd) exp_len = len_pend;
    exp_v = rd;
    if (rd) begin
      exp_d = pop_b;
      exp_t = pop_t;
      data_out = pop_b;
    end else begin
      data_out = 8'($urandom);
    end
    vld_out = vld_gate && (fifo_b.size() > 0);
  endtask

  task automatic drive();
    if (mode == 1) begin
      sink_ready = ($urandom_range(0, 3) != 0);
      vld_gate   = ($urandom_range(0, 9) != 0);
    end else if (mode == 2) begin
      sink_ready = !sink_ready;
      vld_gate   = 1'b1;
    end else begin
      sink_ready = 1'b1;
      vld_gate   = 1'b1;
    end
    vld_out = vld_gate && (fifo_b.size() > 0);
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((fifo_b.size() > 0 || exp_v) && n < budget) begin
      drive();
      cyc();
      n++;
    end
    sink_ready = 1'b1;
    vld_gate = 1'b1;
    vld_out = (fifo_b.size() > 0);
    repeat (3) cyc();
    chk("drain", 32'(fifo_b.size()), 32'd0);
  endtask

  task automatic lat_check(input string tag);
    int lat;
    lat = 0;
    while (lat < 60) begin
      cyc();
      if (last_rd) break;
      lat++;
    end
    chk(tag, 32'(lat), 32'(LAT));
  endtask

  task automatic wait_payload();
    int n;
    n = 0;
    last_rd = 1'b0;
    while (!(last_rd && last_t == 1) && n < 60) begin
      cyc();
      n++;
    end
    chk("payload_seen", 32'(last_rd && last_t == 1), 32'd1);
  endtask

  initial begin
    logic [7:0]  hdr;
    logic [63:0] pld;
    logic [7:0]  par;
    rst = 1'b0;
    vld_out = 1'b0;
    soft_reset = 1'b0;
    sink_ready = 1'b1;
    data_out = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b1;

    // good packet, unthrottled sink
    pld = 64'h0000_0000_00AA_55AA;
    push_pkt(8'h0E, pld, par_of(8'h0E, pld));
    lat_check("first_rd_lat");
    run_idle(100);
    chk("good_a", 32'(good_cnt), 32'd1);
    chk("err_a", 32'(err_cnt), 32'd0);

    // same packet with a bad parity byte
    push_pkt(8'h0E, pld, 8'hFF);
    lat_check("bad_rd_lat");
    run_idle(100);
    chk("good_b", 32'(good_cnt), 32'd1);
    chk("err_b", 32'(err_cnt), 32'd1);

    // alternating sink_ready
    mode = 2;
    pld = {$urandom, $urandom};
    push_pkt(8'h16, pld, par_of(8'h16, pld));
    run_idle(200);
    mode = 0;

    // zero-length packet
    push_pkt(8'h01, 64'd0, 8'h01);
    run_idle(100);
    chk("good_len0", 32'(good_cnt), 32'd3);

    // soft_reset while idle does nothing
    soft_reset = 1'b1;
    cyc();
    soft_reset = 1'b0;
    cyc();

    // abort on the second payload read, then a clean packet
    pld = {$urandom, $urandom};
    push_pkt(8'h10, pld, par_of(8'h10, pld));
    wait_payload();
    soft_reset = 1'b1;
    exp_abort = 1'b1;
    cyc();
    soft_reset = 1'b0;
    exp_abort = 1'b0;
    pld = {$urandom, $urandom};
    push_pkt(8'h0D, pld, par_of(8'h0D, pld));
    lat_check("post_abort_lat");
    run_idle(100);
    chk("good_abort", 32'(good_cnt), 32'd4);
    chk("err_abort", 32'(err_cnt), 32'd1);

    // randomized packets, back-to-back bursts, throttled sink and vld_out
    mode = 1;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 3; k++) begin
        hdr = {6'($urandom_range(0, 8)), 2'($urandom_range(0, 3))};
        pld = {$urandom, $urandom};
        par = par_of(hdr, pld);
        if ($urandom_range(0, 2) == 0) par = par ^ 8'($urandom_range(1, 255));
        push_pkt(hdr, pld, par);
      end
      run_idle(600);
    end
    mode = 0;

    // synchronous reset in the middle of the payload
    pld = {$urandom, $urandom};
    push_pkt(8'h18, pld, par_of(8'h18, pld));
    wait_payload();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    reset_checks();

    // error counter saturation with back-to-back zero-length packets
    hdr_cyc.delete();
    for (int k = 0; k < 257; k++) push_pkt(8'h01, 64'd0, 8'hFE);
    run_idle(5000);
    chk("err_sat", 32'(err_cnt), 32'd255);
    chk("good_sat", 32'(good_cnt), 32'd0);
    chk("hdr_count", 32'(hdr_cyc.size()), 32'd257);
    for (int k = 0; k < 3; k++)
      if (hdr_cyc.size() > k + 1)
        chk("b2b_period", 32'(hdr_cyc[k+1] - hdr_cyc[k]), 32'(LAT + 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
